ucsbece154b_icache: RTL and testbench
=====================================

Name: ucsbece154b_icache

Overview:
Set-associative instruction cache between the pipelined core's fetch stage and the shared main-memory port. It consumes the core's next-PC and fetch-enable and returns the instruction with a ready flag that stalls fetch on a miss. Misses refill a whole block from memory as a burst of word beats. A core misprediction during a refill suppresses delivery of the stale instruction.

Parameters:
NUM_SETS, 8, number of sets (power of 2)
NUM_WAYS, 2, associativity (power of 2)
BLOCK_WORDS, 4, 32-bit words per block (power of 2)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
ReadEnable  input  1  fetch request (core ~StallF)
ReadAddress  input  32  next PC (PCNewF); bits [1:0] ignored
Misprediction  input  1  core redirect in Execute
Instruction  output  32  fetched instruction (InstrF)
Ready  output  1  Instruction valid for the current PC (ReadyF)
MemReadAddress  output  32  block-aligned refill address
MemReadRequest  output  1  refill request, held until accepted
Busy  input  1  memory port busy; request not accepted while high
MemDataIn  input  32  refill beat data
MemDataReady  input  1  one beat valid this cycle

Behaviour:
- Address split: offset = [OFF+1:2], OFF = log2(BLOCK_WORDS); index = next log2(NUM_SETS) bits; tag = remaining upper bits.
- Reset (reset==0, asynchronous): all valid bits 0, victim pointers 0, FSM IDLE, Ready 0, Instruction 0, MemReadRequest 0, MemReadAddress 0, abort flag 0. Reset asserted mid-refill drops the burst; the line is not installed.
- FSM states: IDLE, REQ, FILL, DELIVER.
- IDLE, ReadEnable==0: Instruction and Ready hold their values.
- IDLE, ReadEnable==1: tags are compared at the edge.
  - Hit: next cycle Ready=1 and Instruction=word. One-cycle latency, back-to-back hits every cycle.
  - Miss: next cycle Ready=0; latch the address; go to REQ.
- Misprediction in IDLE has no effect, because a new address follows.
- REQ: MemReadRequest=1, MemReadAddress={tag,index,OFF+2 zeros}.
  - Accepted at the first edge with Busy==0; go to FILL and drop MemReadRequest.
  - MemReadAddress holds stable until the last beat.
- FILL: each cycle with MemDataReady==1 writes beat k (k counts 0..BLOCK_WORDS-1, in ascending word order) into a line buffer. MemDataReady in other states is ignored.
- Last beat:
  - Install the line into the victim way. Victim is the lowest-index invalid way; if none is invalid, the set's round-robin pointer, which then increments mod NUM_WAYS.
  - Set valid and tag.
  - Go to DELIVER.
- DELIVER (one cycle):
  - If abort==0, Ready=1 and Instruction=requested word.
  - Then clear abort, go to IDLE, and perform a normal lookup if ReadEnable==1 this cycle.
- Abort: Misprediction==1 in REQ or FILL sets abort. The refill always completes and installs; only delivery is suppressed, with Ready held 0. The redirected address is looked up after DELIVER, so the core holds PCNewF until Ready.
- Ready is 0 in REQ and FILL.
- Hit/miss is never reported for an address whose line is mid-fill; lookups occur only in IDLE/DELIVER.
- A hit and a simultaneous install in the same set cannot occur.

Decomposition:
- Shared package: FSM state encodings, and derived widths OFF_W, IDX_W, TAG_W as localparam functions of the parameters.
- One sub-module, ucsbece154b_icache_way: valid/tag/data arrays for one way, with lookup port (index, tag -> hit, word) and install port (index, tag, block). Instantiate NUM_WAYS times via generate; the top holds the FSM, line buffer, victim pointers and output mux.

Test Plan:
- Cold miss: reset, ReadEnable=1, ReadAddress=0x0000_0040, Busy=0, beats 0x11,0x22,0x33,0x44 -> MemReadRequest=1 with MemReadAddress=0x40; Ready=1, Instruction=0x11 the cycle after beat 4.
- Hit streaming: after the cold miss, addresses 0x44, 0x48, 0x4C on consecutive cycles -> Ready=1 each next cycle with 0x22, 0x33, 0x44; MemReadRequest stays 0.
- Conflict/replacement: fill 0x040, 0x240, 0x440 (same index, NUM_WAYS=2) -> the third fill evicts way 0. Then 0x040 misses and 0x240 hits.
- Busy handshake: miss with Busy=1 for 5 cycles -> MemReadRequest=1 and address stable throughout; FILL starts only after Busy falls.
- Misprediction mid-refill: Misprediction pulse during beat 2 of the 0x80 refill, new ReadAddress=0x100 -> no Ready for 0x80; the 0x80 line is installed (a later access hits); 0x100 miss refill starts after DELIVER.
- Stall hold and reset mid-fill: ReadEnable=0 after a hit -> Instruction/Ready unchanged. reset=0 during FILL -> all outputs 0 immediately; re-access of the same address misses.

Source files
------------

// File: rtl/ucsbece154b_icache_pkg.sv
// Shared definitions for the instruction cache: FSM states and address-field widths.
package ucsbece154b_icache_pkg;

    localparam int XLEN            = 32;
    localparam int NUM_SETS_DEF    = 8;
    localparam int NUM_WAYS_DEF    = 2;
    localparam int BLOCK_WORDS_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_FILL    = 2'd2,
        S_DELIVER = 2'd3
    } state_t;

    function automatic int off_w(input int block_words);
        return $clog2(block_words);
    endfunction

    function automatic int idx_w(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_w(input int num_sets, input int block_words);
        return XLEN - idx_w(num_sets) - off_w(block_words) - 2;
    endfunction

    function automatic int way_w(input int num_ways);
        return (num_ways > 1) ? $clog2(num_ways) : 1;
    endfunction

    localparam int OFF_W = off_w(BLOCK_WORDS_DEF);
    localparam int IDX_W = idx_w(NUM_SETS_DEF);
    localparam int TAG_W = tag_w(NUM_SETS_DEF, BLOCK_WORDS_DEF);

endpackage

// File: rtl/ucsbece154b_icache_way.sv
// One cache way: valid/tag/data arrays with a combinational lookup port and a
// whole-block install port.
module ucsbece154b_icache_way #(
    parameter int NUM_SETS    = 8,
    parameter int BLOCK_WORDS = 4,
    parameter int IDX_BITS    = 3,
    parameter int OFF_BITS    = 2,
    parameter int TAG_BITS    = 25
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [IDX_BITS-1:0]          lookup_index,
    input  logic [TAG_BITS-1:0]          lookup_tag,
    input  logic [OFF_BITS-1:0]          lookup_offset,
    output logic                         hit,
    output logic [31:0]                  word,
    input  logic [IDX_BITS-1:0]          probe_index,
    output logic                         probe_valid,
    input  logic                         install_en,
    input  logic [IDX_BITS-1:0]          install_index,
    input  logic [TAG_BITS-1:0]          install_tag,
    input  logic [BLOCK_WORDS-1:0][31:0] install_block
);

    logic [NUM_SETS-1:0]          valid_q;
    logic [TAG_BITS-1:0]          tag_q  [NUM_SETS];
    logic [BLOCK_WORDS-1:0][31:0] data_q [NUM_SETS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (install_en) begin
            valid_q[install_index] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays carry no reset; valid_q gates every use, so they can map to RAM.
    always_ff @(posedge clk) begin
        if (install_en) begin
            tag_q[install_index]  <= install_tag;
            data_q[install_index] <= install_block;
        end
    end

    assign hit         = valid_q[lookup_index] && (tag_q[lookup_index] == lookup_tag);
    assign word        = data_q[lookup_index][lookup_offset];
    assign probe_valid = valid_q[probe_index];

endmodule

// File: rtl/ucsbece154b_icache.sv
// Set-associative instruction cache: one-cycle hits, burst refill on miss, and
// suppression of the refilled instruction when the core mispredicts mid-refill.
module ucsbece154b_icache
    import ucsbece154b_icache_pkg::*;
#(
    parameter int NUM_SETS    = NUM_SETS_DEF,
    parameter int NUM_WAYS    = NUM_WAYS_DEF,
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReadEnable,
    input  logic [31:0] ReadAddress,
    input  logic        Misprediction,
    output logic [31:0] Instruction,
    output logic        Ready,
    output logic [31:0] MemReadAddress,
    output logic        MemReadRequest,
    input  logic        Busy,
    input  logic [31:0] MemDataIn,
    input  logic        MemDataReady
);

    localparam int OFF_BITS = off_w(BLOCK_WORDS);
    localparam int IDX_BITS = idx_w(NUM_SETS);
    localparam int TAG_BITS = tag_w(NUM_SETS, BLOCK_WORDS);
    localparam int WAY_BITS = way_w(NUM_WAYS);

    localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(BLOCK_WORDS - 1);
    localparam logic [WAY_BITS-1:0] LAST_WAY  = WAY_BITS'(NUM_WAYS - 1);

    typedef logic [BLOCK_WORDS-1:0][31:0] block_t;

    logic [OFF_BITS-1:0] lk_off;
    logic [IDX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0] lk_tag;
    logic [1:0]          unused_byte_off;

    assign lk_off          = ReadAddress[OFF_BITS+1:2];
    assign lk_idx          = ReadAddress[OFF_BITS+2 +: IDX_BITS];
    assign lk_tag          = ReadAddress[31 -: TAG_BITS];
    assign unused_byte_off = ReadAddress[1:0];

    state_t              state_q;
    logic                abort_q;
    logic [OFF_BITS-1:0] beat_q;
    logic [TAG_BITS-1:0] req_tag_q;
    logic [IDX_BITS-1:0] req_idx_q;
    logic [OFF_BITS-1:0] req_off_q;
    block_t              line_buf_q;
    logic [WAY_BITS-1:0] rr_q [NUM_SETS];

    logic [NUM_WAYS-1:0] way_hit;
    logic [NUM_WAYS-1:0] way_valid;
    logic [31:0]         way_word [NUM_WAYS];
    logic                hit;
    logic [31:0]         hit_word;
    logic                install_en;
    block_t              fill_block;
    logic [WAY_BITS-1:0] victim;
    logic                victim_free;

    assign install_en = (state_q == S_FILL) && MemDataReady && (beat_q == LAST_BEAT);

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        ucsbece154b_icache_way #(
            .NUM_SETS    (NUM_SETS),
            .BLOCK_WORDS (BLOCK_WORDS),
            .IDX_BITS    (IDX_BITS),
            .OFF_BITS    (OFF_BITS),
            .TAG_BITS    (TAG_BITS)
        ) u_way (
            .clk           (clk),
            .reset         (reset),
            .lookup_index  (lk_idx),
            .lookup_tag    (lk_tag),
            .lookup_offset (lk_off),
            .hit           (way_hit[w]),
            .word          (way_word[w]),
            .probe_index   (req_idx_q),
            .probe_valid   (way_valid[w]),
            .install_en    (install_en && (victim == WAY_BITS'(w))),
            .install_index (req_idx_q),
            .install_tag   (req_tag_q),
            .install_block (fill_block)
        );
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        hit      = |way_hit;
        hit_word = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (way_hit[w]) hit_word = hit_word | way_word[w];
        end
    end

    // Descending scan so the lowest-index invalid way wins; otherwise round-robin.
    always_comb begin
        victim      = rr_q[req_idx_q];
        victim_free = 1'b0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) begin
                victim      = WAY_BITS'(w);
                victim_free = 1'b1;
            end
        end
    end

    always_comb begin
        fill_block                  = line_buf_q;
        fill_block[BLOCK_WORDS - 1] = MemDataIn;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            abort_q        <= 1'b0;
            beat_q         <= '0;
            req_tag_q      <= '0;
            req_idx_q      <= '0;
            req_off_q      <= '0;
            line_buf_q     <= '0;
            Ready          <= 1'b0;
            Instruction    <= '0;
            MemReadRequest <= 1'b0;
            MemReadAddress <= '0;
            for (int s = 0; s < NUM_SETS; s++) rr_q[s] <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DELIVER: begin
                    abort_q <= 1'b0;
                    state_q <= S_IDLE;
                    if (ReadEnable) begin
                        if (hit) begin
                            Ready       <= 1'b1;
                            Instruction <= hit_word;
                        end else begin
                            Ready          <= 1'b0;
                            req_tag_q      <= lk_tag;
                            req_idx_q      <= lk_idx;
                            req_off_q      <= lk_off;
                            MemReadRequest <= 1'b1;
                            MemReadAddress <= {lk_tag, lk_idx, {(OFF_BITS + 2){1'b0}}};
                            state_q        <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (Misprediction) abort_q <= 1'b1;
                    if (!Busy) begin
                        MemReadRequest <= 1'b0;
                        beat_q         <= '0;
                        state_q        <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (Misprediction) abort_q <= 1'b1;
                    if (MemDataReady) begin
                        line_buf_q[beat_q] <= MemDataIn;
                        beat_q             <= beat_q + 1'b1;
                        if (beat_q == LAST_BEAT) begin
                            state_q <= S_DELIVER;
                            if (!(abort_q || Misprediction)) begin
                                Ready       <= 1'b1;
                                Instruction <= fill_block[req_off_q];
                            end
                            if (!victim_free) begin
                                rr_q[req_idx_q] <= (rr_q[req_idx_q] == LAST_WAY) ? '0 : rr_q[req_idx_q] + 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ucsbece154b_icache.sv
// Self-checking bench: the bench plays both core and memory, and predicts hits
// from a block-address model of each set.
module tb_ucsbece154b_icache;

    localparam int NUM_SETS    = 8;
    localparam int NUM_WAYS    = 2;
    localparam int BLOCK_WORDS = 4;
    localparam int BLOCK_BYTES = BLOCK_WORDS * 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ReadEnable;
    logic [31:0] ReadAddress;
    logic        Misprediction;
    logic [31:0] Instruction;
    logic        Ready;
    logic [31:0] MemReadAddress;
    logic        MemReadRequest;
    logic        Busy;
    logic [31:0] MemDataIn;
    logic        MemDataReady;

    always #5 clk = ~clk;

    ucsbece154b_icache #(
        .NUM_SETS    (NUM_SETS),
        .NUM_WAYS    (NUM_WAYS),
        .BLOCK_WORDS (BLOCK_WORDS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ReadEnable     (ReadEnable),
        .ReadAddress    (ReadAddress),
        .Misprediction  (Misprediction),
        .Instruction    (Instruction),
        .Ready          (Ready),
        .MemReadAddress (MemReadAddress),
        .MemReadRequest (MemReadRequest),
        .Busy           (Busy),
        .MemDataIn      (MemDataIn),
        .MemDataReady   (MemDataReady)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: which block base address each (set, way) holds.
    bit        m_valid [NUM_SETS][NUM_WAYS];
    bit [31:0] m_blk   [NUM_SETS][NUM_WAYS];
    int        m_rr    [NUM_SETS];
    bit [31:0] mem_over [bit [31:0]];
    logic        exp_ready;
    logic [31:0] exp_instr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] mem_word(input bit [31:0] a);
        if (mem_over.exists(a)) return mem_over[a];
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic bit [31:0] block_of(input bit [31:0] a);
        return a - (a % 32'(BLOCK_BYTES));
    endfunction

    function automatic int set_of(input bit [31:0] a);
        return int'((a / 32'(BLOCK_BYTES)) % 32'(NUM_SETS));
    endfunction

    function automatic bit m_hit(input bit [31:0] a);
        for (int w = 0; w < NUM_WAYS; w++)
            if (m_valid[set_of(a)][w] && m_blk[set_of(a)][w] == block_of(a)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_install(input bit [31:0] a);
        int s;
        int way;
        s   = set_of(a);
        way = -1;
        for (int w = 0; w < NUM_WAYS; w++)
            if (!m_valid[s][w] && way < 0) way = w;
        if (way < 0) begin
            way     = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % NUM_WAYS;
        end
        m_valid[s][way] = 1'b1;
        m_blk[s][way]   = block_of(a);
    endfunction

    function automatic void m_reset();
        for (int s = 0; s < NUM_SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < NUM_WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_blk[s][w]   = '0;
            end
        end
    endfunction

    // One fetch of address a, starting at a negedge; on a miss the bench serves
    // the refill, optionally stalling on Busy and redirecting mid-refill.
    task automatic access(input bit [31:0] a, input int nbusy, input bit mp_req,
                          input int mp_beat, input bit [31:0] redirect);
        bit [31:0] base;
        bit        aborted;
        base          = block_of(a);
        ReadAddress   = a;
        ReadEnable    = 1'b1;
        Misprediction = ($urandom_range(0, 3) == 0);
        @(posedge clk);
        @(negedge clk);
        Misprediction = 1'b0;
        if (m_hit(a)) begin
            exp_ready = 1'b1;
            exp_instr = mem_word(a);
            check("hit_ready", Ready, exp_ready);
            check("hit_instr", Instruction, exp_instr);
            check("hit_no_req", MemReadRequest, 0);
            return;
        end
        check("miss_ready", Ready, 0);
        check("miss_req", MemReadRequest, 1);
        check("miss_addr", MemReadAddress, base);
        for (int i = 0; i < nbusy; i++) begin
            Busy          = 1'b1;
            Misprediction = mp_req && (i == 0);
            MemDataReady  = 1'($urandom_range(0, 1));
            MemDataIn     = $urandom;
            @(posedge clk);
            @(negedge clk);
            check("busy_req", MemReadRequest, 1);
            check("busy_addr", MemReadAddress, base);
            check("busy_ready", Ready, 0);
        end
        Busy          = 1'b0;
        Misprediction = mp_req && (nbusy == 0);
        MemDataReady  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        Misprediction = 1'b0;
        check("accept_req", MemReadRequest, 0);
        check("accept_ready", Ready, 0);
        aborted = mp_req;
        for (int k = 0; k < BLOCK_WORDS; k++) begin
            repeat ($urandom_range(0, 2)) begin
                MemDataReady = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check("gap_ready", Ready, 0);
            end
            MemDataIn     = mem_word(base + 32'(4 * k));
            MemDataReady  = 1'b1;
            Misprediction = (k == mp_beat);
            if (k == mp_beat) begin
                ReadAddress = redirect;
                aborted     = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            MemDataReady  = 1'b0;
            Misprediction = 1'b0;
            if (k < BLOCK_WORDS - 1) begin
                check("fill_ready", Ready, 0);
                check("fill_addr", MemReadAddress, base);
            end
        end
        m_install(a);
        if (!aborted) begin
            exp_ready = 1'b1;
            exp_instr = mem_word(a);
        end else begin
            exp_ready = 1'b0;
        end
        check("deliver_ready", Ready, exp_ready);
        check("deliver_instr", Instruction, exp_instr);
    endtask

    task automatic stall(input int n);
        ReadEnable = 1'b0;
        for (int i = 0; i < n; i++) begin
            ReadAddress   = $urandom;
            Misprediction = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            check("stall_ready", Ready, exp_ready);
            check("stall_instr", Instruction, exp_instr);
        end
        Misprediction = 1'b0;
    endtask

    task automatic reset_mid_fill(input bit [31:0] a);
        ReadAddress = a;
        ReadEnable  = 1'b1;
        Busy        = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            MemDataIn    = mem_word(block_of(a) + 32'(4 * k));
            MemDataReady = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        MemDataReady = 1'b0;
        reset        = 1'b0;
        #1;
        check("rst_fill_ready", Ready, 0);
        check("rst_fill_instr", Instruction, 0);
        check("rst_fill_req", MemReadRequest, 0);
        check("rst_fill_addr", MemReadAddress, 0);
        m_reset();
        exp_ready = 1'b0;
        exp_instr = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        bit [31:0] a;
        bit [31:0] r;
        reset         = 1'b0;
        ReadEnable    = 1'b0;
        ReadAddress   = '0;
        Misprediction = 1'b0;
        Busy          = 1'b0;
        MemDataIn     = '0;
        MemDataReady  = 1'b0;
        exp_ready     = 1'b0;
        exp_instr     = '0;
        mem_over[32'h40] = 32'h11;
        mem_over[32'h44] = 32'h22;
        mem_over[32'h48] = 32'h33;
        mem_over[32'h4C] = 32'h44;
        m_reset();

        repeat (2) @(negedge clk);
        check("reset_ready", Ready, 0);
        check("reset_instr", Instruction, 0);
        check("reset_req", MemReadRequest, 0);
        check("reset_addr", MemReadAddress, 0);
        reset = 1'b1;
        @(negedge clk);

        // Cold miss, then streaming hits in the same block.
        access(32'h40, 0, 1'b0, -1, 0);
        access(32'h44, 0, 1'b0, -1, 0);
        access(32'h48, 0, 1'b0, -1, 0);
        access(32'h4C, 0, 1'b0, -1, 0);

        // Three blocks on one index: the third evicts way 0.
        access(32'h240, 0, 1'b0, -1, 0);
        access(32'h440, 0, 1'b0, -1, 0);
        access(32'h240, 0, 1'b0, -1, 0);
        access(32'h040, 0, 1'b0, -1, 0);

        access(32'h600, 5, 1'b0, -1, 0);

        // Redirect during the second beat of the 0x80 refill.
        access(32'h80, 0, 1'b0, 1, 32'h100);
        access(32'h100, 0, 1'b0, -1, 0);
        access(32'h80, 0, 1'b0, -1, 0);

        access(32'h84, 0, 1'b0, -1, 0);
        stall(4);
        reset_mid_fill(32'h384);
        access(32'h384, 0, 1'b0, -1, 0);

        for (int i = 0; i < 40; i++) begin
            a = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, NUM_SETS - 1)) << 4)
              | (32'($urandom_range(0, BLOCK_WORDS - 1)) << 2);
            r = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, NUM_SETS - 1)) << 4);
            access(a, $urandom_range(0, 3), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 4) == 0) ? $urandom_range(0, BLOCK_WORDS - 1) : -1, r);
            if ($urandom_range(0, 4) == 0) stall(2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
